// File: rtl/bias_seq_ctrl.sv
// bias_seq_ctrl: loads a bias vector into the inactive cascade registers and promotes it on request.
module bias_seq_ctrl #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic         backward_in,
  input  logic [W-1:0] bias_in,
  input  logic         bias_in_valid,
  output logic         bias_in_ready,
  input  logic         switch_req_in,
  output logic         load_bias_out,
  output logic [W-1:0] bias_scalar_out,
  output logic         bias_switch_out,
  output logic         bias_backward_out,
  output logic         armed_out,
  output logic         err_out
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, SHIFT = 2'd2, ARMED = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] fill_cnt, shift_cnt;
  logic          pending_mode;
  logic [W-1:0]  bias_buf [N];
  logic          go;
  assign go = start_in & (state == IDLE | (state == ARMED & switch_req_in));
  // Outputs are computed one edge ahead so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      fill_cnt          <= '0;
      shift_cnt         <= '0;
      pending_mode      <= 1'b0;
      bias_in_ready     <= 1'b0;
      load_bias_out     <= 1'b0;
      bias_scalar_out   <= '0;
      bias_switch_out   <= 1'b0;
      bias_backward_out <= 1'b0;
      armed_out         <= 1'b0;
      err_out           <= 1'b0;
      for (int i = 0; i < N; i++) bias_buf[i] <= '0;
    end else begin
      bias_switch_out <= 1'b0;
      err_out         <= switch_req_in & (state != ARMED);
      case (state)
        FILL: if (bias_in_valid & bias_in_ready) begin
          bias_buf[fill_cnt] <= bias_in;
          fill_cnt           <= fill_cnt + 1'b1;
          if (fill_cnt == CW'(N - 1)) begin
            state           <= SHIFT;
            bias_in_ready   <= 1'b0;
            load_bias_out   <= 1'b1;
            bias_scalar_out <= bias_in;
            shift_cnt       <= '0;
          end
        end
        SHIFT: if (shift_cnt == CW'(N - 1)) begin
          state           <= ARMED;
          load_bias_out   <= 1'b0;
          bias_scalar_out <= '0;
          armed_out       <= 1'b1;
        end else begin
          shift_cnt       <= shift_cnt + 1'b1;
          bias_scalar_out <= bias_buf[CW'(N - 2) - shift_cnt];
        end
        ARMED: if (switch_req_in) begin
          bias_switch_out   <= 1'b1;
          bias_backward_out <= pending_mode;
          armed_out         <= 1'b0;
          state             <= IDLE;
        end
        default: ;
      endcase
      if (go) begin
        state         <= FILL;
        pending_mode  <= backward_in;
        fill_cnt      <= '0;
        shift_cnt     <= '0;
        bias_in_ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bias_seq_ctrl.sv
// tb_bias_seq_ctrl: directed vectors with a queue scoreboard checking strobes and switch pulses.
module tb_bias_seq_ctrl;
  localparam int N = 4, W = 16;
  logic clk = 0, rst = 1, start_in = 0, backward_in = 0, bias_in_valid = 0, switch_req_in = 0;
  logic [W-1:0] bias_in = '0;
  logic bias_in_ready, load_bias_out, bias_switch_out, bias_backward_out, armed_out, err_out;
  logic [W-1:0] bias_scalar_out;
  int checks = 0, errors = 0, err_seen = 0;
  logic [W-1:0] sq [$];
  logic mq [$];

  bias_seq_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .backward_in(backward_in),
    .bias_in(bias_in), .bias_in_valid(bias_in_valid), .bias_in_ready(bias_in_ready),
    .switch_req_in(switch_req_in), .load_bias_out(load_bias_out),
    .bias_scalar_out(bias_scalar_out), .bias_switch_out(bias_switch_out),
    .bias_backward_out(bias_backward_out), .armed_out(armed_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe and switch pulse must match the head of its queue.
  always @(negedge clk) begin
    if (load_bias_out) begin
      if (sq.size() == 0) chk("unexpected_strobe", 32'(bias_scalar_out), 32'hdead);
      else chk("scalar", 32'(bias_scalar_out), 32'(sq.pop_front()));
    end else if (bias_scalar_out !== '0) chk("scalar_idle", 32'(bias_scalar_out), 0);
    if (bias_switch_out) begin
      if (mq.size() == 0) chk("unexpected_switch", 32'(bias_switch_out), 0);
      else chk("switch_mode", 32'(bias_backward_out), 32'(mq.pop_front()));
    end
    if (err_out) err_seen++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_vec(input logic bwd);
    start_in = 1; backward_in = bwd;
    tick();
    start_in = 0; backward_in = 0;
  endtask

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    while (!bias_in_ready && n < 20) begin tick(); n++; end
    if (!bias_in_ready) chk("ready_timeout", 0, 1);
    bias_in_valid = 1; bias_in = v;
    tick();
    bias_in_valid = 0; bias_in = '0;
  endtask

  task automatic stream(input logic [4*W-1:0] vv, input bit gaps, input int npush);
    for (int i = N - 1; i >= N - npush; i--) sq.push_back(vv[W*i +: W]);
    for (int i = 0; i < N; i++) begin
      if (gaps && i == 1) begin tick(); tick(); end
      if (gaps && i == 3) tick();
      send(vv[W*i +: W]);
    end
  endtask

  task automatic wait_armed();
    int n = 0;
    while (!armed_out && n < 30) begin tick(); n++; end
    chk("armed", 32'(armed_out), 1);
    chk("strobes_done", 32'(sq.size()), 0);
  endtask

  task automatic do_switch(input logic exp_mode);
    mq.push_back(exp_mode);
    switch_req_in = 1;
    tick();
    switch_req_in = 0;
    chk("switch_pulse", 32'(bias_switch_out), 1);
    chk("backward", 32'(bias_backward_out), 32'(exp_mode));
    chk("disarmed", 32'(armed_out), 0);
    tick();
    chk("switch_single", 32'(bias_switch_out), 0);
    chk("backward_hold", 32'(bias_backward_out), 32'(exp_mode));
  endtask

  initial begin
    tick(); tick();
    chk("reset_outs", 32'({bias_in_ready, load_bias_out, bias_scalar_out, bias_switch_out,
                           bias_backward_out, armed_out, err_out}), 0);
    rst = 0;
    tick();
    // Basic vector, backward mode
    start_vec(1);
    chk("ready_fill", 32'(bias_in_ready), 1);
    stream({16'd40, 16'd30, 16'd20, 16'd10}, 0, 4);
    chk("ready_after_fill", 32'(bias_in_ready), 0);
    wait_armed();
    do_switch(1);
    // Gapped fill, switch request during shift flags an error
    start_vec(0);
    stream({16'hfff8, 16'd7, 16'hfffa, 16'd5}, 1, 4);
    for (int n = 0; n < 10 && !load_bias_out; n++) tick();
    switch_req_in = 1;
    tick();
    switch_req_in = 0;
    chk("no_switch_in_shift", 32'(bias_switch_out), 0);
    chk("err_pulse", 32'(err_out), 1);
    tick();
    chk("err_single", 32'(err_out), 0);
    wait_armed();
    chk("err_count", 32'(err_seen), 1);
    do_switch(0);
    // Switch and restart in the same cycle
    start_vec(1);
    stream({16'h7fff, 16'h8000, 16'h0001, 16'hffff}, 0, 4);
    wait_armed();
    mq.push_back(1'b1);
    switch_req_in = 1; start_in = 1; backward_in = 0;
    tick();
    switch_req_in = 0; start_in = 0;
    chk("combo_switch", 32'(bias_switch_out), 1);
    chk("combo_backward_old", 32'(bias_backward_out), 1);
    chk("combo_fill", 32'(bias_in_ready), 1);
    stream({16'd4, 16'd3, 16'd2, 16'd1}, 0, 4);
    wait_armed();
    do_switch(0);
    // Reset on shift cycle 2 abandons the vector
    start_vec(1);
    stream({16'd400, 16'd300, 16'd200, 16'd100}, 0, 3);
    for (int n = 0; n < 10 && !load_bias_out; n++) tick();
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_outs", 32'({bias_in_ready, load_bias_out, bias_scalar_out, bias_switch_out,
                         bias_backward_out, armed_out, err_out}), 0);
    tick(); tick();
    chk("rst_no_strobe", 32'(load_bias_out), 0);
    chk("rst_queue", 32'(sq.size()), 0);
    start_vec(1);
    stream({16'd44, 16'd33, 16'd22, 16'd11}, 0, 4);
    wait_armed();
    do_switch(1);
    tick(); tick();
    chk("err_total", 32'(err_seen), 1);
    chk("switch_queue", 32'(mq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
